// File: rtl/seq_detect_counter_pkg.sv
// Shared types, 7-segment tables and BCD helper for the serial pattern detector.
package seq_det_pkg;

  localparam logic [6:0] SEG7_ZERO = 7'b1000000;
  localparam logic [6:0] SEG7_ERR  = 7'b0000111;

  // Active-low {g..a} segment codes for digits 0-9
  localparam logic [6:0] SEG7 [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } match_st_e;

  // Returns {carry_out, digit_out}; a set carry_in adds one with decimal rollover
  function automatic logic [4:0] bcd_inc(input logic [3:0] digit, input logic carry_in);
    logic [4:0] res;
    if (!carry_in) begin
      res = {1'b0, digit};
    end else if (digit >= 4'd9) begin
      res = {1'b1, 4'd0};
    end else begin
      res = {1'b0, digit + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_detect_counter_if.sv
// Configuration, sample and result bundle between the input synchroniser side and the detector.
interface seq_detect_counter_if #(
  parameter int PRE_MAX    = 8,
  parameter int NUM_DIGITS = 2
) ();

  localparam int LEN_W = $clog2(PRE_MAX + 1);

  logic                    ena;
  logic                    sig_to_test;
  logic [PRE_MAX-1:0]      pre_pattern;
  logic [LEN_W-1:0]        pre_len;
  logic                    gap_en;
  logic                    gap_bit;
  logic                    final_bit;
  logic                    cfg_overlap;
  logic                    cfg_load;
  logic                    clr_count;
  logic                    z;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    overflow;
  logic [7*NUM_DIGITS-1:0] disp;

  modport master (
    output ena, sig_to_test, pre_pattern, pre_len, gap_en, gap_bit, final_bit,
           cfg_overlap, cfg_load, clr_count,
    input  z, count, overflow, disp
  );

  modport slave (
    input  ena, sig_to_test, pre_pattern, pre_len, gap_en, gap_bit, final_bit,
           cfg_overlap, cfg_load, clr_count,
    output z, count, overflow, disp
  );

endinterface

// File: rtl/seq_detect_counter_seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment pattern; non-BCD values show an error glyph.
module seg7_decoder
  import seq_det_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  // Table lookup guarded against codes 10-15
  always_comb begin
    o_seg = SEG7_ERR;
    if (i_digit <= 4'd9) begin
      o_seg = SEG7[i_digit];
    end else begin
      o_seg = SEG7_ERR;
    end
  end

endmodule

// File: rtl/seq_detect_counter.sv
// Programmable PREFIX.GAP*.FINAL serial detector feeding a BCD hit counter and
// registered 7-segment outputs.
module seq_detect_counter
  import seq_det_pkg::*;
#(
  parameter int PRE_MAX    = 8,
  parameter int NUM_DIGITS = 2,
  parameter int WRAP       = 0
) (
  input  logic                clk,
  input  logic                rst,
  seq_detect_counter_if.slave bus
);

  localparam int              LEN_W     = $clog2(PRE_MAX + 1);
  localparam logic [LEN_W-1:0] PRE_MAX_L = LEN_W'(PRE_MAX);

  match_st_e               r_st;
  match_st_e               w_st_nxt;
  match_st_e               w_st_seed;
  logic [PRE_MAX-1:0]      r_h;
  logic [PRE_MAX-1:0]      w_h_nxt;
  logic [PRE_MAX-1:0]      w_h_shift;
  logic [PRE_MAX-1:0]      w_mask;
  logic [LEN_W-1:0]        r_fill;
  logic [LEN_W-1:0]        w_fill_nxt;
  logic [LEN_W-1:0]        w_fill_inc;
  logic [LEN_W-1:0]        w_len;
  logic                    w_pm;
  logic                    w_hit;

  logic                    r_z;
  logic                    r_ovf;
  logic [4*NUM_DIGITS-1:0] r_count;
  logic [4*NUM_DIGITS-1:0] w_count_inc;
  logic [NUM_DIGITS:0]     w_carry;
  logic                    w_all9;
  logic [7*NUM_DIGITS-1:0] w_seg;
  logic [7*NUM_DIGITS-1:0] r_disp;

  // Effective prefix length and the bit mask it selects out of the history
  always_comb begin
    w_len  = (bus.pre_len > PRE_MAX_L) ? PRE_MAX_L : bus.pre_len;
    w_mask = '0;
    for (int i = 0; i < PRE_MAX; i++) begin
      if (LEN_W'(i) < w_len) begin
        w_mask[i] = 1'b1;
      end else begin
        w_mask[i] = 1'b0;
      end
    end
  end

  assign w_h_shift  = (r_h << 1) | PRE_MAX'(bus.sig_to_test);
  assign w_fill_inc = (r_fill >= PRE_MAX_L) ? PRE_MAX_L : r_fill + LEN_W'(1);
  // Zero-length prefix masks everything away, so the match is unconditional
  assign w_pm       = (w_fill_inc >= w_len) && (((w_h_shift ^ bus.pre_pattern) & w_mask) == '0);
  assign w_st_seed  = w_pm ? ST_ARMED : ST_IDLE;

  // Matcher next-state: final bit wins over gap bit when both equal the sample
  always_comb begin
    w_st_nxt   = r_st;
    w_h_nxt    = r_h;
    w_fill_nxt = r_fill;
    w_hit      = 1'b0;
    if (bus.cfg_load) begin
      w_st_nxt   = ST_IDLE;
      w_h_nxt    = '0;
      w_fill_nxt = '0;
    end else if (bus.ena) begin
      case (r_st)
        ST_ARMED: begin
          if (bus.sig_to_test == bus.final_bit) begin
            w_hit = 1'b1;
            if (bus.cfg_overlap) begin
              w_st_nxt   = w_st_seed;
              w_h_nxt    = w_h_shift;
              w_fill_nxt = w_fill_inc;
            end else begin
              w_st_nxt   = ST_IDLE;
              w_h_nxt    = '0;
              w_fill_nxt = '0;
            end
          end else if (bus.gap_en && (bus.sig_to_test == bus.gap_bit)) begin
            w_st_nxt   = ST_ARMED;
            w_h_nxt    = w_h_shift;
            w_fill_nxt = w_fill_inc;
          end else begin
            w_st_nxt   = w_st_seed;
            w_h_nxt    = w_h_shift;
            w_fill_nxt = w_fill_inc;
          end
        end
        ST_IDLE: begin
          w_st_nxt   = w_st_seed;
          w_h_nxt    = w_h_shift;
          w_fill_nxt = w_fill_inc;
        end
        default: begin
          w_st_nxt   = ST_IDLE;
          w_h_nxt    = '0;
          w_fill_nxt = '0;
        end
      endcase
    end else begin
      w_hit = 1'b0;
    end
  end

  // Matcher state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= ST_IDLE;
      r_h    <= '0;
      r_fill <= '0;
    end else begin
      r_st   <= w_st_nxt;
      r_h    <= w_h_nxt;
      r_fill <= w_fill_nxt;
    end
  end

  // Ripple-carry BCD increment; carry out of the top digit means the count is all-9s
  assign w_carry[0] = 1'b1;
  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    logic [4:0] w_dsum;
    assign w_dsum              = bcd_inc(r_count[4*d +: 4], w_carry[d]);
    assign w_carry[d+1]        = w_dsum[4];
    assign w_count_inc[4*d +: 4] = w_dsum[3:0];

    seg7_decoder u_seg (
      .i_digit (r_count[4*d +: 4]),
      .o_seg   (w_seg[7*d +: 7])
    );
  end
  assign w_all9 = w_carry[NUM_DIGITS];

  // Hit pulse, counter and sticky overflow; a clear drops a coincident increment
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z     <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_z <= w_hit;
      if (bus.clr_count) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_hit) begin
        if (w_all9) begin
          r_ovf <= 1'b1;
          if (WRAP != 0) begin
            r_count <= '0;
          end else begin
            r_count <= r_count;
          end
        end else begin
          r_count <= w_count_inc;
        end
      end else begin
        r_count <= r_count;
      end
    end
  end

  // Display register, one cycle behind the count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp <= {NUM_DIGITS{SEG7_ZERO}};
    end else begin
      r_disp <= w_seg;
    end
  end

  assign bus.z        = r_z;
  assign bus.count    = r_count;
  assign bus.overflow = r_ovf;
  assign bus.disp     = r_disp;

endmodule

// File: tb/tb_seq_detect_counter.sv
// Randomised and directed bench for seq_detect_counter (saturating and wrapping builds side by side)
// checked every cycle against a sample-list reference model.
module tb_seq_detect_counter;

  localparam int PM   = 8;
  localparam int ND   = 2;
  localparam int MAXC = 99;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       ena, sig, cfg_load, clr;
  logic [7:0] pat;
  logic [3:0] plen;
  logic       gap_en, gap_bit, final_bit, ovl;

  seq_detect_counter_if #(.PRE_MAX(PM), .NUM_DIGITS(ND)) bus0 ();
  seq_detect_counter_if #(.PRE_MAX(PM), .NUM_DIGITS(ND)) bus1 ();

  assign bus0.ena = ena;          assign bus1.ena = ena;
  assign bus0.sig_to_test = sig;  assign bus1.sig_to_test = sig;
  assign bus0.pre_pattern = pat;  assign bus1.pre_pattern = pat;
  assign bus0.pre_len = plen;     assign bus1.pre_len = plen;
  assign bus0.gap_en = gap_en;    assign bus1.gap_en = gap_en;
  assign bus0.gap_bit = gap_bit;  assign bus1.gap_bit = gap_bit;
  assign bus0.final_bit = final_bit; assign bus1.final_bit = final_bit;
  assign bus0.cfg_overlap = ovl;  assign bus1.cfg_overlap = ovl;
  assign bus0.cfg_load = cfg_load; assign bus1.cfg_load = cfg_load;
  assign bus0.clr_count = clr;    assign bus1.clr_count = clr;

  seq_detect_counter #(.PRE_MAX(PM), .NUM_DIGITS(ND), .WRAP(0)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  seq_detect_counter #(.PRE_MAX(PM), .NUM_DIGITS(ND), .WRAP(1)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  // ---------------- reference model ----------------
  int seg_q[$];       // samples since the last point the matcher forgot everything
  int m_cnt [2];
  bit m_ovf [2];
  int m_disp_cnt [2];
  bit m_z;
  bit m_valid = 1'b0;
  bit m_hit;
  int m_len, m_t;

  function automatic bit prefix_ends_at(int k, int len);
    for (int i = 0; i < len; i++) begin
      if (k - i < 0) return 1'b0;
      if (seg_q[k - i] != int'(pat[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Hit when the sample equals final_bit and, looking back through a run of gap
  // bits, some earlier sample completed the prefix
  always @(posedge clk) begin
    if (rst) begin
      seg_q.delete();
      m_z = 1'b0;
      m_valid = 1'b1;
      for (int w = 0; w < 2; w++) begin
        m_cnt[w] = 0; m_ovf[w] = 1'b0; m_disp_cnt[w] = 0;
      end
    end else begin
      m_hit = 1'b0;
      if (cfg_load) begin
        seg_q.delete();
      end else if (ena) begin
        seg_q.push_back(int'(sig));
        m_t = seg_q.size() - 1;
        m_len = (plen > 4'd8) ? 8 : int'(plen);
        if (sig == final_bit) begin
          for (int k = m_t - 1; k >= 0; k--) begin
            if (prefix_ends_at(k, m_len)) begin
              m_hit = 1'b1;
              break;
            end
            if (!(gap_en && seg_q[k] == int'(gap_bit) && gap_bit != final_bit)) break;
          end
        end
        if (m_hit && !ovl) seg_q.delete();
      end
      m_z = m_hit;
      for (int w = 0; w < 2; w++) begin
        m_disp_cnt[w] = m_cnt[w];
        if (clr) begin
          m_cnt[w] = 0; m_ovf[w] = 1'b0;
        end else if (m_hit) begin
          if (m_cnt[w] == MAXC) begin
            m_ovf[w] = 1'b1;
            m_cnt[w] = (w == 1) ? 0 : MAXC;
          end else begin
            m_cnt[w] = m_cnt[w] + 1;
          end
        end
      end
    end
  end

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0011000;
      default: return 7'b0000111;
    endcase
  endfunction

  function automatic logic [13:0] disp_of(int v);
    logic [7:0] b;
    b = to_bcd(v);
    return {seg_of(b[7:4]), seg_of(b[3:0])};
  endfunction

  // ---------------- checking ----------------
  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (m_valid) begin
      chk("z_sat",     32'(bus0.z),        32'(m_z));
      chk("z_wrap",    32'(bus1.z),        32'(m_z));
      chk("cnt_sat",   32'(bus0.count),    32'(to_bcd(m_cnt[0])));
      chk("cnt_wrap",  32'(bus1.count),    32'(to_bcd(m_cnt[1])));
      chk("ovf_sat",   32'(bus0.overflow), 32'(m_ovf[0]));
      chk("ovf_wrap",  32'(bus1.overflow), 32'(m_ovf[1]));
      chk("disp_sat",  32'(bus0.disp),     32'(disp_of(m_disp_cnt[0])));
      chk("disp_wrap", 32'(bus1.disp),     32'(disp_of(m_disp_cnt[1])));
    end
  endtask

  // One clock: inputs applied now, captured on the rising edge, outputs checked on the falling edge
  task automatic cyc(input logic b, input logic e);
    sig = b;
    ena = e;
    @(negedge clk);
    compare_all();
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic ge,
                          input logic gb, input logic fb, input logic ov);
    pat = p; plen = l; gap_en = ge; gap_bit = gb; final_bit = fb; ovl = ov;
    cfg_load = 1'b1; clr = 1'b1;
    cyc(1'b0, 1'b0);
    cfg_load = 1'b0; clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) cyc(bits[i], 1'b1);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; sig = 1'b0; cfg_load = 1'b0; clr = 1'b0;
    pat = 8'h01; plen = 4'd2; gap_en = 1'b1; gap_bit = 1'b0; final_bit = 1'b1; ovl = 1'b1;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_z",     32'(bus0.z),        32'd0);
    chk("rst_count", 32'(bus0.count),    32'h00);
    chk("rst_ovf",   32'(bus0.overflow), 32'd0);
    chk("rst_disp",  32'(bus0.disp),     32'(14'b1000000_1000000));

    // Base pattern 01[0*]1: stream 0,1,0,0,0,1
    load_cfg(8'h01, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 5; i >= 0; i--) begin
      logic [5:0] s;
      s = 6'b010001;
      cyc(s[i], 1'b1);
      chk("p1_z", 32'(bus0.z), (i == 0) ? 32'd1 : 32'd0);
    end
    chk("p1_count", 32'(bus0.count), 32'h01);
    chk("p1_model", 32'(m_cnt[0]), 32'd1);
    cyc(1'b0, 1'b0);
    chk("p1_disp0", 32'(bus0.disp[6:0]),  32'(7'b1111001));
    chk("p1_disp1", 32'(bus0.disp[13:7]), 32'(7'b1000000));

    // Overlap on/off with 0,1,0,1,0,1
    load_cfg(8'h01, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    send(8'b010101, 6);
    chk("p2_ovl1", 32'(bus0.count), 32'h02);
    load_cfg(8'h01, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    send(8'b010101, 6);
    chk("p2_ovl0", 32'(bus0.count), 32'h01);

    // Gap enable and zero-length gap
    load_cfg(8'h01, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'b01001, 5);
    chk("p3_nogap", 32'(bus0.count), 32'h00);
    load_cfg(8'h01, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    send(8'b01001, 5);
    chk("p3_gap", 32'(bus0.count), 32'h01);
    load_cfg(8'h01, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    send(8'b011, 3);
    chk("p3_zero_gap", 32'(bus0.count), 32'h01);

    // Sample enable gating: disabled cycles carry 1s that must be ignored
    load_cfg(8'h01, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1); cyc(1'b1, 1'b0); cyc(1'b1, 1'b1); cyc(1'b1, 1'b0);
    chk("p4_gated", 32'(bus0.count), 32'h01);

    // 100 hits: empty prefix, every 1 after the first hits
    load_cfg(8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 101; i++) cyc(1'b1, 1'b1);
    chk("p5_sat_cnt",  32'(bus0.count),    32'h99);
    chk("p5_sat_ovf",  32'(bus0.overflow), 32'd1);
    chk("p5_wrap_cnt", 32'(bus1.count),    32'h00);
    chk("p5_wrap_ovf", 32'(bus1.overflow), 32'd1);
    chk("p5_model",    32'(m_cnt[1]),      32'd0);
    cyc(1'b0, 1'b0);
    chk("p5_disp", 32'(bus0.disp), 32'(14'b0011000_0011000));

    // Clear coinciding with a hit, while overflow is set
    clr = 1'b1;
    cyc(1'b1, 1'b1);
    clr = 1'b0;
    chk("p6_clr_cnt", 32'(bus0.count),    32'h00);
    chk("p6_clr_ovf", 32'(bus0.overflow), 32'd0);
    chk("p6_clr_ovw", 32'(bus1.overflow), 32'd0);

    // Reset while armed kills the pending match
    load_cfg(8'h01, 4'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1); cyc(1'b1, 1'b1);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b1);
    chk("p6_rst_z",   32'(bus0.z),     32'd0);
    chk("p6_rst_cnt", 32'(bus0.count), 32'h00);

    // Randomised traffic with occasional reconfiguration, clears and resets
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        pat = 8'($urandom);
        plen = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        gap_en = 1'($urandom); gap_bit = 1'($urandom);
        final_bit = 1'($urandom); ovl = 1'($urandom);
        cfg_load = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) clr = 1'b1;
      if ($urandom_range(0, 699) == 0) rst = 1'b1;
      cyc(1'($urandom), ($urandom_range(0, 3) != 0));
      cfg_load = 1'b0; clr = 1'b0; rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
